alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_if.sv | 27 ++
 rtl/alu_md.sv | 142 ++++++++++++++
 tb/tb_alu_md.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_if.sv
// Operation/result handshake bundle for alu_md.
// Carries the offered operation (valid/ready) and the registered result (valid/ready).
// master drives operations and out_ready; slave answers with in_ready, out_valid and res.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [2:0]      op;
  logic            alt;
  logic            mext;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;

  modport master (
    output in_valid, src_a, src_b, op, alt, mext, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, src_a, src_b, op, alt, mext, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/alu_md.sv
// Integer ALU with RV M-extension: base ops single-cycle, MUL*/DIV*/REM* iterative (one bit per cycle).
// Latency: base ops and divide-by-zero/overflow 1 cycle; other M ops XLEN+1 cycles to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY and in DONE without out_ready.
module alu_md #(
  parameter int XLEN = 32
) (
  input logic    clk,
  input logic    rst_n,
  alu_md_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int DW  = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state, w_next;
  logic [SHW:0]    r_cnt;
  logic [XLEN-1:0] r_b;
  logic [DW-1:0]   r_acc;
  logic [XLEN-1:0] r_res;
  logic [2:0]      r_op;
  logic            r_neg;
  logic            r_aneg;

  logic            w_accept, w_iter, w_div, w_bzero, w_ovf;
  logic            w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_quick, w_sra, w_fin;
  logic [SHW-1:0]  w_sh;
  logic [XLEN:0]   w_madd, w_cand, w_diff;
  logic            w_ge;
  logic [DW-1:0]   w_mstep, w_dstep, w_step, w_prod;

  assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign bus.out_valid = (r_state == DONE);
  assign bus.res       = r_res;
  assign w_accept      = bus.in_valid && bus.in_ready;

  // Operand decode at acceptance: signedness, magnitudes, bypass conditions
  assign w_div   = bus.op[2];
  assign w_sgn_a = bus.mext && (w_div ? ~bus.op[0] : (bus.op[1] ^ bus.op[0]));
  assign w_sgn_b = bus.mext && (w_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01));
  assign w_a_neg = w_sgn_a && bus.src_a[XLEN-1];
  assign w_b_neg = w_sgn_b && bus.src_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -bus.src_a : bus.src_a;
  assign w_b_mag = w_b_neg ? -bus.src_b : bus.src_b;
  assign w_bzero = (bus.src_b == '0);
  assign w_ovf   = w_div && ~bus.op[0] && (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
  assign w_iter  = bus.mext && !(w_div && (w_bzero || w_ovf));
  assign w_sh    = bus.src_b[SHW-1:0];
  // Kept separate so the arithmetic shift is not turned unsigned by a mixed ternary
  assign w_sra   = $signed(bus.src_a) >>> w_sh;

  // Single-cycle results: base ops plus the divide-by-zero and overflow shortcuts
  always_comb begin
    w_quick = '0;
    if (!bus.mext) begin
      case (bus.op)
        3'b000:  w_quick = bus.alt ? (bus.src_a - bus.src_b) : (bus.src_a + bus.src_b);
        3'b001:  w_quick = bus.src_a << w_sh;
        3'b010:  w_quick = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
        3'b011:  w_quick = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
        3'b100:  w_quick = bus.src_a ^ bus.src_b;
        3'b101:  w_quick = bus.alt ? w_sra : (bus.src_a >> w_sh);
        3'b110:  w_quick = bus.src_a | bus.src_b;
        default: w_quick = bus.src_a & bus.src_b;
      endcase
    end else if (w_bzero) begin
      w_quick = bus.op[1] ? bus.src_a : '1;
    end else if (w_ovf) begin
      w_quick = bus.op[1] ? '0 : bus.src_a;
    end
  end

  // One iteration step: shift-add multiply on {hi, multiplier}, restoring divide on {rem, quotient}
  assign w_madd  = {1'b0, r_acc[DW-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mstep = {w_madd, r_acc[XLEN-1:1]};
  assign w_cand  = r_acc[DW-1:XLEN-1];
  assign w_diff  = w_cand - {1'b0, r_b};
  assign w_ge    = ~w_diff[XLEN];
  assign w_dstep = {(w_ge ? w_diff[XLEN-1:0] : w_cand[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
  assign w_step  = r_op[2] ? w_dstep : w_mstep;
  assign w_prod  = r_neg ? -w_step : w_step;

  // Sign fix-up and result selection applied on the last iteration
  always_comb begin
    w_fin = '0;
    if (!r_op[2]) begin
      w_fin = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[DW-1:XLEN];
    end else if (r_op[1]) begin
      w_fin = r_aneg ? -w_step[DW-1:XLEN] : w_step[DW-1:XLEN];
    end else begin
      w_fin = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    end
  end

  // Next-state: DONE is left only through the out_ready handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_iter ? BUSY : DONE;
      BUSY:    if (r_cnt == 1) w_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (w_accept) w_next = w_iter ? BUSY : DONE;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_res  <= '0;
      r_op   <= '0;
      r_neg  <= 1'b0;
      r_aneg <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.op;
      r_neg  <= w_a_neg ^ w_b_neg;
      r_aneg <= w_a_neg;
      r_b    <= w_b_mag;
      r_acc  <= {{XLEN{1'b0}}, w_a_mag};
      r_cnt  <= w_iter ? (SHW+1)'(XLEN) : '0;
      if (!w_iter) r_res <= w_quick;
    end else if (r_state == BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == 1) r_res <= w_fin;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed vector table, random ops vs. arithmetic model,
// backpressure, reset-abort and an XLEN=8 instance.
module tb_alu_md;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_md_if #(.XLEN(32)) bus();
  alu_md_if #(.XLEN(8))  bus8();

  alu_md #(.XLEN(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_md #(.XLEN(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [2:0]  op;
    logic        alt;
    logic        mext;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference results straight from the RISC-V definitions, using wide integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic alt, input logic mext,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    int ia, ib;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    sh = b[4:0];
    if (!mext) begin
      case (op)
        3'd0: return alt ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return (ia < ib) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (alt) return 32'(ia >>> sh);
          return a >> sh;
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] op, input logic mext,
                                   input logic [31:0] a, input logic [31:0] b);
    if (!mext) return 1;
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Offer one op, scribble on inputs while waiting, check result, latency and hold after handshake
  task automatic run32(input logic [2:0] op, input logic alt, input logic mext,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input string name);
    int lat;
    bit got;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.alt = alt; bus.mext = mext;
    bus.src_a = a; bus.src_b = b; bus.out_ready = 1'b0;
    chk(64'(bus.in_ready), 64'd1, {name, " in_ready"});
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin
        got = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.src_a = $urandom; bus.src_b = $urandom;
        bus.op = 3'($urandom_range(0, 7)); bus.mext = 1'($urandom_range(0, 1));
      end
    end
    chk(64'(lat), 64'(exp_lat), {name, " latency"});
    chk(64'(bus.res), 64'(exp_res), {name, " res"});
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk(64'(bus.out_valid), 64'd0, {name, " out_valid after handshake"});
    chk(64'(bus.res), 64'(exp_res), {name, " res held"});
  endtask

  task automatic run8(input logic [2:0] op, input logic mext, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat,
                      input string name);
    int lat;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = op; bus8.alt = 1'b0; bus8.mext = mext;
    bus8.src_a = a; bus8.src_b = b; bus8.out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 50 && !bus8.out_valid; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      lat++;
    end
    chk(64'(lat), 64'(exp_lat), {name, " latency"});
    chk(64'(bus8.res), 64'(exp_res), {name, " res"});
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        alt, mext;
    logic [31:0] specials[5];

    tbl[0]  = '{3'd0, 1'b1, 1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE, 1,  "sub"};
    tbl[1]  = '{3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4,          32'hF800_0000, 1,  "sra"};
    tbl[2]  = '{3'd1, 1'b0, 1'b0, 32'd1,          32'h21,         32'd2,         1,  "sll"};
    tbl[3]  = '{3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd1,         1,  "slt"};
    tbl[4]  = '{3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,         1,  "sltu"};
    tbl[5]  = '{3'd7, 1'b0, 1'b0, 32'hF0F0,      32'hFF00,       32'hF000,      1,  "and"};
    tbl[6]  = '{3'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0,         33, "mulh"};
    tbl[7]  = '{3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, "mulhu"};
    tbl[8]  = '{3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         33, "mul"};
    tbl[9]  = '{3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, "mulhsu"};
    tbl[10] = '{3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, "div"};
    tbl[11] = '{3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, "rem"};
    tbl[12] = '{3'd5, 1'b0, 1'b1, 32'h8000_0000, 32'd0,          32'hFFFF_FFFF, 1,  "divu_by0"};
    tbl[13] = '{3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1,  "div_ovf"};
    tbl[14] = '{3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1,  "rem_ovf"};
    tbl[15] = '{3'd7, 1'b0, 1'b1, 32'd7,          32'd0,          32'd7,         1,  "remu_by0"};
    tbl[16] = '{3'd5, 1'b0, 1'b1, 32'd100,        32'd7,          32'd14,        33, "divu"};
    tbl[17] = '{3'd7, 1'b0, 1'b1, 32'd100,        32'd7,          32'd2,         33, "remu"};

    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    bus.in_valid = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.op = '0;
    bus.alt = 1'b0; bus.mext = 1'b0; bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.src_a = '0; bus8.src_b = '0; bus8.op = '0;
    bus8.alt = 1'b0; bus8.mext = 1'b0; bus8.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk(64'(bus.out_valid), 64'd0, "reset out_valid");
    chk(64'(bus.res), 64'd0, "reset res");
    chk(64'(bus.in_ready), 64'd1, "reset in_ready");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(64'(bus.in_ready), 64'd1, "in_ready after release");

    // Directed vectors
    for (int i = 0; i < 18; i++)
      run32(tbl[i].op, tbl[i].alt, tbl[i].mext, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, tbl[i].name);

    // Random ops against the model, with corner operands mixed in
    for (int i = 0; i < 200; i++) begin
      op   = 3'($urandom_range(0, 7));
      alt  = 1'($urandom_range(0, 1));
      mext = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      run32(op, alt, mext, a, b, model(op, alt, mext, a, b), lat_model(op, mext, a, b), "random");
    end

    // Backpressure: result held, nothing accepted, then same-cycle accept on release
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.alt = 1'b0; bus.mext = 1'b0;
    bus.src_a = 32'd3; bus.src_b = 32'd4; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'd4; bus.src_a = 32'hF0; bus.src_b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      chk(64'(bus.out_valid), 64'd1, "bp out_valid");
      chk(64'(bus.res), 64'd7, "bp res");
      chk(64'(bus.in_ready), 64'd0, "bp in_ready");
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk(64'(bus.in_ready), 64'd1, "bp release in_ready");
    @(negedge clk);
    chk(64'(bus.out_valid), 64'd1, "done->done out_valid");
    chk(64'(bus.res), 64'hFF, "done->done res");
    bus.op = 3'd3; bus.mext = 1'b1; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk(64'(bus.out_valid), 64'd0, "done->busy out_valid");
    chk(64'(bus.in_ready), 64'd0, "done->busy in_ready");
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(64'(lat), 64'd33, "done->busy latency");
    chk(64'(bus.res), 64'hFFFF_FFFE, "done->busy res");
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during an iterative divide
    run32(3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 1, "pre-reset add");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd5; bus.mext = 1'b1;
    bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.out_ready = 1'b0;
    @(posedge clk);
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    chk(64'(bus.out_valid), 64'd0, "busy out_valid");
    rst_n = 1'b0;
    #1;
    chk(64'(bus.out_valid), 64'd0, "abort out_valid");
    chk(64'(bus.res), 64'd0, "abort res");
    chk(64'(bus.in_ready), 64'd1, "abort in_ready");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk(64'(bus.in_ready), 64'd1, "post-abort in_ready");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk(64'(seen), 64'd0, "no stale result");
    bus.out_ready = 1'b0;

    // Narrow datapath
    run8(3'd3, 1'b1, 8'hFF, 8'hFF, 8'hFE, 9, "x8 mulhu");
    run8(3'd1, 1'b0, 8'h01, 8'h0B, 8'h08, 1, "x8 sll");
    run8(3'd4, 1'b1, 8'hF9, 8'h02, 8'hFD, 9, "x8 div");
    run8(3'd6, 1'b1, 8'hF9, 8'h02, 8'hFF, 9, "x8 rem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
